// File: rtl/adm_step_ctrl_if.sv
// Delta-modulator step controller port bundle: run control, comparator input, DAC code and bit handshake.
// master = controller side (drives counter/step/bit), slave = environment side.
interface adm_step_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 5
);
    logic              en;
    logic              comp_res;
    logic [WIDTH-1:0]  counter;
    logic [STEP_W-1:0] step;
    logic              upd;
    logic              bit_out;
    logic              bit_valid;
    logic              bit_ready;
    logic              overrun;

    modport master (
        input  en, comp_res, bit_ready,
        output counter, step, upd, bit_out, bit_valid, overrun
    );

    modport slave (
        output en, comp_res, bit_ready,
        input  counter, step, upd, bit_out, bit_valid, overrun
    );
endinterface

// File: rtl/adm_step_ctrl.sv
// Delta-modulator sequencer: one sample per DIV-cycle slot, saturating counter, CVSD step adapt when DM_ADAPTIVE_EN.
// Latency: counter/step/bit_out update DIV cycles after the slot starts; upd pulses the cycle after UPDATE.
// Backpressure: 1-entry bit buffer; an unaccepted bit is overwritten at the next UPDATE and flags sticky overrun.
module adm_step_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DIV      = 16,
    parameter int RUN_LEN  = 3,
    parameter int STEP_W   = 5,
    parameter int STEP_MIN = 1,
    parameter int STEP_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    adm_step_ctrl_if.master  io
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    localparam int               CNT_W     = $clog2(DIV);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(DIV - 3);
    localparam logic [WIDTH:0]   CNT_MAX   = {1'b0, {WIDTH{1'b1}}};

    if (DIV < 3 || STEP_MIN < 1 || RUN_LEN < 2 || STEP_MAX >= 2**STEP_W || STEP_MAX > 2**WIDTH - 1)
    begin : g_bad_cfg
        $error("adm_step_ctrl: illegal parameter combination");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic             s_q, s_d;
    logic             upd_q, upd_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             overrun_q, overrun_d;
    logic [STEP_W-1:0] step_cur;
    logic [WIDTH:0]   step_ext, sum_up;
    logic [WIDTH-1:0] cnt_up, cnt_dn;

    wire do_sample = io.en && (state_q == ST_SAMPLE);
    wire do_update = io.en && (state_q == ST_UPDATE);

`ifdef DM_ADAPTIVE_EN
    logic [STEP_W-1:0]  step_q, step_d;
    logic [RUN_LEN-1:0] hist_q, hist_d;
    logic [STEP_W:0]    step_dbl;
    logic [STEP_W-1:0]  step_half;

    assign step_cur = step_q;

    // history already holds this slot's sample by the time UPDATE runs
    always_comb begin
        hist_d    = hist_q;
        step_d    = step_q;
        step_dbl  = {step_q, 1'b0};
        step_half = step_q >> 1;
        if (do_sample) begin
            hist_d = {hist_q[RUN_LEN-2:0], io.comp_res};
        end
        if (do_update) begin
            if ((&hist_q) || (~|hist_q)) begin
                step_d = (step_dbl > (STEP_W+1)'(STEP_MAX)) ? STEP_W'(STEP_MAX) : step_dbl[STEP_W-1:0];
            end else begin
                step_d = (step_half < STEP_W'(STEP_MIN)) ? STEP_W'(STEP_MIN) : step_half;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= STEP_W'(STEP_MIN);
            hist_q <= '0;
        end else begin
            step_q <= step_d;
            hist_q <= hist_d;
        end
    end
`else
    assign step_cur = STEP_W'(STEP_MIN);
`endif

    // one extra bit of headroom so saturation is detected instead of wrapping
    always_comb begin
        step_ext = (WIDTH+1)'(step_cur);
        sum_up   = {1'b0, counter_q} + step_ext;
        cnt_up   = (sum_up > CNT_MAX) ? {WIDTH{1'b1}} : sum_up[WIDTH-1:0];
        cnt_dn   = ({1'b0, counter_q} < step_ext) ? '0 : (counter_q - step_ext[WIDTH-1:0]);
    end

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        counter_d   = counter_q;
        s_d         = s_q;
        upd_d       = 1'b0;
        bit_out_d   = bit_out_q;
        bit_valid_d = bit_valid_q;
        overrun_d   = overrun_q;

        if (bit_valid_q && io.bit_ready) begin
            bit_valid_d = 1'b0;
        end

        if (!io.en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_WAIT;
                    div_cnt_d = '0;
                end
                ST_WAIT: begin
                    div_cnt_d = div_cnt_q + 1'b1;
                    if (div_cnt_q == WAIT_LAST) state_d = ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    s_d     = io.comp_res;
                    state_d = ST_UPDATE;
                end
                default: begin
                    counter_d   = s_q ? cnt_up : cnt_dn;
                    upd_d       = 1'b1;
                    bit_out_d   = s_q;
                    bit_valid_d = 1'b1;
                    if (bit_valid_q && !io.bit_ready) overrun_d = 1'b1;
                    state_d     = ST_WAIT;
                    div_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            counter_q   <= '0;
            s_q         <= 1'b0;
            upd_q       <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            counter_q   <= counter_d;
            s_q         <= s_d;
            upd_q       <= upd_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign io.counter   = counter_q;
    assign io.step      = step_cur;
    assign io.upd       = upd_q;
    assign io.bit_out   = bit_out_q;
    assign io.bit_valid = bit_valid_q;
    assign io.overrun   = overrun_q;
endmodule

// File: tb/tb_adm_step_ctrl.sv
// Directed bench for adm_step_ctrl at default parameters; adaptive or linear vectors follow DM_ADAPTIVE_EN.
module tb_adm_step_ctrl;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    adm_step_ctrl_if io ();

    adm_step_ctrl dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // returns negedges waited until upd is seen, -1 on timeout
    task automatic wait_upd(output int n);
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (io.upd === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        io.en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        io.en = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({io.counter, io.step, io.upd, io.bit_out, io.bit_valid, io.overrun} !== {8'd0, 5'd1, 4'b0000}) begin
            fails++;
            $display("FAIL reset: counter=%0d step=%0d upd=%b bit_out=%b valid=%b ovr=%b, want 0/1/0/0/0/0",
                     io.counter, io.step, io.upd, io.bit_out, io.bit_valid, io.overrun);
        end
        rst = 1'b0;
        io.en = 1'b0;
    endtask

`ifdef DM_ADAPTIVE_EN
    task automatic test_adaptive_ramp();
        int n;
        int exp_cnt [22];
        int exp_step[22];
        exp_cnt  = '{1, 2, 3, 5, 9, 17, 33, 49, 65, 81, 97, 113, 129, 145, 161, 177, 193, 209, 225, 241, 255, 255};
        exp_step = '{1, 1, 2, 4, 8, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16};
        do_reset();
        io.comp_res  = 1'b1;
        io.bit_ready = 1'b1;
        io.en        = 1'b1;
        for (int i = 0; i < 22; i++) begin
            wait_upd(n);
            tests++;
            if (io.counter !== 8'(exp_cnt[i]) || io.step !== 5'(exp_step[i]) || n !== ((i == 0) ? 17 : 16)) begin
                fails++;
                $display("FAIL ramp slot %0d: counter=%0d step=%0d period=%0d, want %0d/%0d/%0d",
                         i + 1, io.counter, io.step, n, exp_cnt[i], exp_step[i], (i == 0) ? 17 : 16);
            end
        end
        io.en = 1'b0;
    endtask
`else
    task automatic test_linear();
        int n;
        int exp;
        do_reset();
        io.comp_res  = 1'b1;
        io.bit_ready = 1'b1;
        io.en        = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            wait_upd(n);
            exp = (i < 255) ? i : 255;
            tests++;
            if (io.counter !== 8'(exp) || io.step !== 5'd1 || n !== ((i == 1) ? 17 : 16)) begin
                fails++;
                $display("FAIL lin_up slot %0d: counter=%0d step=%0d period=%0d, want %0d/1/%0d",
                         i, io.counter, io.step, n, exp, (i == 1) ? 17 : 16);
            end
        end
        io.comp_res = 1'b0;
        for (int i = 1; i <= 260; i++) begin
            wait_upd(n);
            exp = (255 - i > 0) ? 255 - i : 0;
            tests++;
            if (io.counter !== 8'(exp) || io.step !== 5'd1 || n !== 16) begin
                fails++;
                $display("FAIL lin_dn slot %0d: counter=%0d step=%0d period=%0d, want %0d/1/16",
                         i, io.counter, io.step, n, exp);
            end
        end
        io.en = 1'b0;
    endtask
`endif

    task automatic test_alternate();
        int n;
        bit exp_s;
        do_reset();
        io.bit_ready = 1'b1;
        io.comp_res  = 1'b1;
        io.en        = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_s = (i % 2 == 0);
            wait_upd(n);
            tests++;
            if (io.counter !== 8'(exp_s) || io.step !== 5'd1 || io.bit_out !== exp_s ||
                io.bit_valid !== 1'b1 || io.overrun !== 1'b0) begin
                fails++;
                $display("FAIL alternate slot %0d: counter=%0d step=%0d bit=%b valid=%b ovr=%b, want %0d/1/%b/1/0",
                         i, io.counter, io.step, io.bit_out, io.bit_valid, io.overrun, exp_s, exp_s);
            end
            io.comp_res = ~exp_s;
        end
        io.en = 1'b0;
    endtask

    task automatic test_overrun();
        int n;
        do_reset();
        io.bit_ready = 1'b0;
        io.comp_res  = 1'b1;
        io.en        = 1'b1;
        wait_upd(n);
        tests++;
        if ({io.bit_out, io.bit_valid, io.overrun} !== 3'b110 || n !== 17) begin
            fails++;
            $display("FAIL ovr_first: bit=%b valid=%b ovr=%b period=%0d, want 1/1/0/17",
                     io.bit_out, io.bit_valid, io.overrun, n);
        end
        io.comp_res = 1'b0;
        wait_upd(n);
        tests++;
        if ({io.bit_out, io.bit_valid, io.overrun} !== 3'b011 || io.counter !== 8'd0) begin
            fails++;
            $display("FAIL ovr_second: bit=%b valid=%b ovr=%b counter=%0d, want 0/1/1/0",
                     io.bit_out, io.bit_valid, io.overrun, io.counter);
        end
        io.bit_ready = 1'b1;
        @(negedge clk);
        tests++;
        if ({io.bit_valid, io.overrun} !== 2'b01) begin
            fails++;
            $display("FAIL ovr_drain: valid=%b ovr=%b, want 0/1", io.bit_valid, io.overrun);
        end
        io.en = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (io.overrun !== 1'b1) begin
            fails++;
            $display("FAIL ovr_sticky: ovr=%b, want 1", io.overrun);
        end
    endtask

    task automatic test_pause_and_reset();
        int n;
        bit saw_upd;
        do_reset();
        io.bit_ready = 1'b1;
        io.comp_res  = 1'b1;
        io.en        = 1'b1;
        wait_upd(n);
        repeat (5) @(negedge clk);
        io.en = 1'b0;
        saw_upd = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (io.upd === 1'b1) saw_upd = 1'b1;
        end
        tests++;
        if (saw_upd !== 1'b0 || io.counter !== 8'd1 || io.step !== 5'd1) begin
            fails++;
            $display("FAIL pause_freeze: saw_upd=%b counter=%0d step=%0d, want 0/1/1", saw_upd, io.counter, io.step);
        end
        io.en = 1'b1;
        wait_upd(n);
        tests++;
        if (n !== 17 || io.counter !== 8'd2) begin
            fails++;
            $display("FAIL pause_resume: delay=%0d counter=%0d, want 17/2", n, io.counter);
        end
        io.bit_ready = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({io.counter, io.step, io.upd, io.bit_out, io.bit_valid, io.overrun} !== {8'd0, 5'd1, 4'b0000}) begin
            fails++;
            $display("FAIL midslot_rst: counter=%0d step=%0d upd=%b bit=%b valid=%b ovr=%b, want 0/1/0/0/0/0",
                     io.counter, io.step, io.upd, io.bit_out, io.bit_valid, io.overrun);
        end
        rst = 1'b0;
        io.en = 1'b0;
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        rst          = 1'b1;
        io.en        = 1'b0;
        io.comp_res  = 1'b0;
        io.bit_ready = 1'b0;
        test_reset();
`ifdef DM_ADAPTIVE_EN
        test_adaptive_ramp();
`else
        test_linear();
`endif
        test_alternate();
        test_overrun();
        test_pause_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
